// File: rtl/hazard_unit_mc_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc_if
//   Bundle of pipeline-status signals consumed by the hazard unit and the
//   hazard control vector it returns to the datapath.
//
//   Signals (REG_WIDTH-wide register indices, all others 1 bit):
//     rsD, rtD, jumpD, stopD              instruction in ID
//     rsE, rtE, WriteRegE, MemReadE,
//     FloatingE, PCSrcE                   instruction in EX
//     WriteRegM, rtM, RegWriteM, MemWriteM instruction in MEM
//     WriteRegW, RegWriteW                instruction in WB
//     hazard_control_vector_o [12:0]      result back to the datapath
//
//   Handshake: there is no valid/ready pair. Every signal is a level that
//   describes the current pipeline contents and is sampled every cycle. The
//   returned vector is a combinational response to that cycle's levels plus
//   the hazard unit's registered state.
//
//   Modports: master = pipeline/datapath side, slave = hazard unit.
// ---------------------------------------------------------------------------
interface hazard_unit_mc_if #(
    parameter int REG_WIDTH = 4
);
    logic [REG_WIDTH-1:0] rsD;
    logic [REG_WIDTH-1:0] rtD;
    logic                 jumpD;
    logic                 stopD;
    logic [REG_WIDTH-1:0] rsE;
    logic [REG_WIDTH-1:0] rtE;
    logic [REG_WIDTH-1:0] WriteRegE;
    logic                 MemReadE;
    logic                 FloatingE;
    logic                 PCSrcE;
    logic [REG_WIDTH-1:0] WriteRegM;
    logic [REG_WIDTH-1:0] rtM;
    logic                 RegWriteM;
    logic                 MemWriteM;
    logic [REG_WIDTH-1:0] WriteRegW;
    logic                 RegWriteW;
    logic [12:0]          hazard_control_vector_o;

    modport master (
        output rsD, rtD, jumpD, stopD,
        output rsE, rtE, WriteRegE, MemReadE, FloatingE, PCSrcE,
        output WriteRegM, rtM, RegWriteM, MemWriteM,
        output WriteRegW, RegWriteW,
        input  hazard_control_vector_o
    );

    modport slave (
        input  rsD, rtD, jumpD, stopD,
        input  rsE, rtE, WriteRegE, MemReadE, FloatingE, PCSrcE,
        input  WriteRegM, rtM, RegWriteM, MemWriteM,
        input  WriteRegW, RegWriteW,
        output hazard_control_vector_o
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc
//   Hazard and forwarding controller for the 16-bit 5-stage pipeline.
//   Produces forwarding selects, store-data forwarding, load-use stalls,
//   branch/jump flushes, multi-cycle (Floating) EX stall sequencing,
//   Stop-drain halt and a saturating stall counter.
//
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   asynchronous active-low reset
//     hz           slave modport of hazard_unit_mc_if (pipeline status in,
//                  hazard_control_vector_o out):
//                  {fwdA[1:0],fwdB[1:0],mem_src,flushEX_MEM,flushIF_ID,
//                   flushID_EX,pcstall,IF_IDstall,ID_EXstall,EX_MEMstall,
//                   MEM_WBstall}
//     busy_o       out  multi-cycle op in progress
//     halted_o     out  pipeline halted by Stop
//     stall_cnt_o  out  cycles with pcstall=1, saturating
//     state_o      out  FSM state (0 IDLE, 1 MC_BUSY, 2 DRAIN, 3 HALT)
// ---------------------------------------------------------------------------
module hazard_unit_mc #(
    parameter int REG_WIDTH       = 4,
    parameter int FP_LATENCY      = 3,
    parameter int DRAIN_CYCLES    = 3,
    parameter int STALL_CNT_WIDTH = 16,
    parameter int R0_IS_ZERO      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    hazard_unit_mc_if.slave            hz,
    output logic                       busy_o,
    output logic                       halted_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
    output logic [1:0]                 state_o
);

    localparam int MC_W    = (FP_LATENCY > 2) ? $clog2(FP_LATENCY) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam bit FP_MULTI = (FP_LATENCY > 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_BUSY = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [MC_W-1:0]      mc_cnt_q, mc_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       mem_src;
    logic       load_use, fp_start;
    logic       flush_ex_mem, flush_if_id, flush_id_ex;
    logic       pcstall, if_id_stall, id_ex_stall;
    logic [12:0] vec;

    // Register index 0 is hard-wired zero when R0_IS_ZERO, so it never
    // produces a dependency.
    function automatic logic match(input logic [REG_WIDTH-1:0] a,
                                   input logic [REG_WIDTH-1:0] b);
        return (a == b) && !((R0_IS_ZERO != 0) && (a == '0));
    endfunction

    // Forwarding is independent of FSM state; MEM is newer than WB so wins.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hz.RegWriteM && match(hz.WriteRegM, hz.rsE))
            fwd_a = 2'b01;
        else if (hz.RegWriteW && match(hz.WriteRegW, hz.rsE))
            fwd_a = 2'b10;
        if (hz.RegWriteM && match(hz.WriteRegM, hz.rtE))
            fwd_b = 2'b01;
        else if (hz.RegWriteW && match(hz.WriteRegW, hz.rtE))
            fwd_b = 2'b10;
        mem_src = hz.MemWriteM && hz.RegWriteW && match(hz.WriteRegW, hz.rtM);
    end

    assign load_use = hz.MemReadE &&
                      (match(hz.WriteRegE, hz.rsD) || match(hz.WriteRegE, hz.rtD));
    assign fp_start = hz.FloatingE && FP_MULTI;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mc_cnt_q    <= '0;
            drain_cnt_q <= '0;
            stall_cnt_o <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            if (pcstall && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + STALL_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        flush_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        pcstall      = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                // A Floating op starting this cycle suppresses the load-use
                // stall; the load-use is seen again once MC_BUSY releases.
                if (hz.PCSrcE) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use && !fp_start) begin
                    pcstall     = 1'b1;
                    if_id_stall = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (hz.jumpD) begin
                    flush_if_id = 1'b1;
                end
                if (fp_start) begin
                    state_d  = MC_BUSY;
                    mc_cnt_d = MC_W'(FP_LATENCY - 2);
                end else if (hz.stopD && !(flush_if_id || flush_id_ex)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
                end
            end
            MC_BUSY: begin
                // Freeze front end, inject a bubble into MEM.
                pcstall      = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                flush_ex_mem = 1'b1;
                if (mc_cnt_q == '0)
                    state_d = IDLE;
                else
                    mc_cnt_d = mc_cnt_q - MC_W'(1);
            end
            DRAIN: begin
                pcstall     = 1'b1;
                if_id_stall = 1'b1;
                flush_id_ex = 1'b1;
                if (drain_cnt_q == '0)
                    state_d = HALT;
                else
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            end
            HALT: begin
                pcstall     = 1'b1;
                if_id_stall = 1'b1;
                flush_id_ex = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Later stages never freeze, so the two low bits are constant zero.
    assign vec = {fwd_a, fwd_b, mem_src, flush_ex_mem, flush_if_id, flush_id_ex,
                  pcstall, if_id_stall, id_ex_stall, 1'b0, 1'b0};

    // The vector is forced to zero while reset is held, even though the
    // forwarding part is purely combinational.
    assign hz.hazard_control_vector_o = rst ? vec : 13'd0;
    assign busy_o   = (state_q == MC_BUSY);
    assign halted_o = (state_q == HALT);
    assign state_o  = state_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_mc
//   Directed bench for hazard_unit_mc (FP_LATENCY=3, DRAIN_CYCLES=3,
//   STALL_CNT_WIDTH=4). Inputs change 1 time unit after the rising edge,
//   outputs are sampled on the falling edge.
//   Vector bit weights: fwdA 12:11, fwdB 10:9, mem_src 0x100,
//   flushEX_MEM 0x80, flushIF_ID 0x40, flushID_EX 0x20, pcstall 0x10,
//   IF_IDstall 0x08, ID_EXstall 0x04.
// ---------------------------------------------------------------------------
module tb_hazard_unit_mc;

    logic       clk;
    logic       rst;
    logic       busy_o;
    logic       halted_o;
    logic [3:0] stall_cnt_o;
    logic [1:0] state_o;
    int         total;
    int         bad;

    hazard_unit_mc_if #(.REG_WIDTH(4)) hz ();

    hazard_unit_mc #(
        .REG_WIDTH      (4),
        .FP_LATENCY     (3),
        .DRAIN_CYCLES   (3),
        .STALL_CNT_WIDTH(4),
        .R0_IS_ZERO     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hz         (hz),
        .busy_o     (busy_o),
        .halted_o   (halted_o),
        .stall_cnt_o(stall_cnt_o),
        .state_o    (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] vec_e,
                           input logic [31:0] busy_e, input logic [31:0] halt_e,
                           input logic [31:0] cnt_e, input logic [31:0] st_e);
        chk({tag, "_vec"},   32'(hz.hazard_control_vector_o), vec_e);
        chk({tag, "_busy"},  32'(busy_o), busy_e);
        chk({tag, "_halt"},  32'(halted_o), halt_e);
        chk({tag, "_cnt"},   32'(stall_cnt_o), cnt_e);
        chk({tag, "_state"}, 32'(state_o), st_e);
    endtask

    // drivers
    task automatic clear_inputs();
        hz.rsD = '0; hz.rtD = '0; hz.jumpD = 1'b0; hz.stopD = 1'b0;
        hz.rsE = '0; hz.rtE = '0; hz.WriteRegE = '0;
        hz.MemReadE = 1'b0; hz.FloatingE = 1'b0; hz.PCSrcE = 1'b0;
        hz.WriteRegM = '0; hz.rtM = '0; hz.RegWriteM = 1'b0; hz.MemWriteM = 1'b0;
        hz.WriteRegW = '0; hz.RegWriteW = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();
        // Forwarding condition present during reset: vector must stay 0.
        hz.RegWriteM = 1'b1; hz.WriteRegM = 4'd1; hz.rsE = 4'd1;
        #2;
        chk_all("reset", 32'h0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b1;

        // 1: MEM wins over WB for rsE; rtE has no producer.
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.WriteRegM = 4'd1;
        hz.RegWriteW = 1'b1; hz.WriteRegW = 4'd1;
        hz.rsE = 4'd1; hz.rtE = 4'd2;
        sample(); chk("fwd_mem_wins", 32'(hz.hazard_control_vector_o), 32'h0800);
        next_cycle();
        // fwdA from MEM, fwdB from WB.
        hz.WriteRegW = 4'd3; hz.rtE = 4'd3;
        sample(); chk("fwd_a01_b10", 32'(hz.hazard_control_vector_o), 32'h0C00);
        next_cycle();
        // Register 0 never forwards.
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
        sample(); chk("fwd_r0", 32'(hz.hazard_control_vector_o), 32'h0);
        next_cycle();
        // Store-data forwarding from WB.
        clear_inputs();
        hz.MemWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.WriteRegW = 4'd5; hz.rtM = 4'd5;
        sample(); chk_all("mem_src", 32'h0100, 0, 0, 0, 0);
        next_cycle();

        // 2: load-use one-cycle stall, then forward from MEM.
        clear_inputs();
        hz.MemReadE = 1'b1; hz.WriteRegE = 4'd2; hz.rsD = 4'd3; hz.rtD = 4'd2;
        sample(); chk_all("load_use", 32'h0038, 0, 0, 0, 0);
        next_cycle();
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.WriteRegM = 4'd2; hz.rsE = 4'd2;
        sample(); chk_all("load_use_fwd", 32'h0800, 0, 0, 1, 0);
        next_cycle();

        // 3: Floating op together with a load-use; load-use suppressed on entry.
        clear_inputs();
        hz.FloatingE = 1'b1;
        hz.MemReadE = 1'b1; hz.WriteRegE = 4'd2; hz.rtD = 4'd2;
        sample(); chk_all("fp_entry", 32'h0, 0, 0, 1, 0);
        next_cycle();
        hz.FloatingE = 1'b0;
        sample(); chk_all("fp_busy1", 32'h009C, 1, 0, 1, 1);
        next_cycle();
        sample(); chk_all("fp_busy2", 32'h009C, 1, 0, 2, 1);
        next_cycle();
        // Released: the pending load-use is now seen.
        sample(); chk_all("fp_release", 32'h0038, 0, 0, 3, 0);
        next_cycle();

        // Jump alone flushes IF/ID.
        clear_inputs();
        hz.jumpD = 1'b1;
        sample(); chk_all("jump", 32'h0040, 0, 0, 4, 0);
        next_cycle();

        // 4: taken branch beats load-use and Stop.
        clear_inputs();
        hz.PCSrcE = 1'b1; hz.stopD = 1'b1;
        hz.MemReadE = 1'b1; hz.WriteRegE = 4'd2; hz.rtD = 4'd2;
        sample(); chk_all("branch", 32'h0060, 0, 0, 4, 0);
        next_cycle();
        clear_inputs();
        sample(); chk_all("branch_after", 32'h0, 0, 0, 4, 0);
        next_cycle();

        // 5: Stop drains for 3 cycles, then halts.
        hz.stopD = 1'b1;
        sample(); chk_all("stop_seen", 32'h0, 0, 0, 4, 0);
        next_cycle();
        clear_inputs();
        sample(); chk_all("drain1", 32'h0038, 0, 0, 4, 2);
        next_cycle();
        sample(); chk_all("drain2", 32'h0038, 0, 0, 5, 2);
        next_cycle();
        sample(); chk_all("drain3", 32'h0038, 0, 0, 6, 2);
        next_cycle();
        hz.RegWriteW = 1'b1; hz.WriteRegW = 4'd4; hz.rsE = 4'd4;
        sample(); chk_all("halt", 32'h1038, 0, 1, 7, 3);
        next_cycle();

        // 6: counter saturates while halted.
        clear_inputs();
        for (int i = 0; i < 20; i++) next_cycle();
        sample(); chk_all("saturate", 32'h0038, 0, 1, 15, 3);
        next_cycle();

        // Reset leaves HALT; then reset again mid-MC_BUSY.
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        sample(); chk_all("halt_reset", 32'h0, 0, 0, 0, 0);
        next_cycle();
        hz.FloatingE = 1'b1;
        next_cycle();
        hz.FloatingE = 1'b0;
        hz.RegWriteM = 1'b1; hz.WriteRegM = 4'd1; hz.rsE = 4'd1;
        #1;
        chk("mid_busy_pre", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk_all("mid_busy_rst", 32'h0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
